// File: rtl/hamming_pair_encoder_if.sv
// rtl/hamming_pair_encoder_if.sv - nibble-in / codeword-pair-out handshake bundle
interface hamming_pair_encoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [3:0]       in_data;
    logic [2:0]       err_pos;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       code_word1;
    logic [6:0]       code_word2;
    logic [CNT_W-1:0] pair_cnt;

    // Nibble source and pair sink side
    modport master (
        output in_valid, in_data, err_pos, flush, out_ready,
        input  in_ready, out_valid, code_word1, code_word2, pair_cnt
    );

    // Encoder side
    modport slave (
        input  in_valid, in_data, err_pos, flush, out_ready,
        output in_ready, out_valid, code_word1, code_word2, pair_cnt
    );
endinterface

// File: rtl/hamming_pair_encoder.sv
// rtl/hamming_pair_encoder.sv - streaming Hamming(7,4) encoder packing codewords in pairs
module hamming_pair_encoder #(
    parameter bit ERR_INJ = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hamming_pair_encoder_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       enc_raw;
    logic [6:0]       err_mask;
    logic [6:0]       enc_word;
    logic [6:0]       cw1_q;
    logic [6:0]       cw2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept;
    logic             handoff;
    logic             load_cw1;
    logic             load_cw2;
    logic             pad_cw2;

    // Codeword of the nibble on the input, with the optional single-bit flip
    always_comb begin
        enc_raw[0] = bus.in_data[0] ^ bus.in_data[1] ^ bus.in_data[3];
        enc_raw[1] = bus.in_data[0] ^ bus.in_data[2] ^ bus.in_data[3];
        enc_raw[2] = bus.in_data[0];
        enc_raw[3] = bus.in_data[1] ^ bus.in_data[2] ^ bus.in_data[3];
        enc_raw[4] = bus.in_data[1];
        enc_raw[5] = bus.in_data[2];
        enc_raw[6] = bus.in_data[3];
        err_mask   = '0;
        if (ERR_INJ && (bus.err_pos != 3'd0)) begin
            err_mask = 7'd1 << (bus.err_pos - 3'd1);
        end
        enc_word = enc_raw ^ err_mask;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept in HALF wins over flush; FULL leaves only on handoff
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = HALF;
            HALF:  if (accept || bus.flush) state_nxt = FULL;
            FULL:  if (bus.out_ready) state_nxt = accept ? HALF : EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake outputs and datapath load strobes decoded from the state
    always_comb begin
        in_ready_c  = (state != FULL) || bus.out_ready;
        out_valid_c = (state == FULL);
        accept      = bus.in_valid && in_ready_c;
        handoff     = out_valid_c && bus.out_ready;
        load_cw1    = accept && (state != HALF);
        load_cw2    = accept && (state == HALF);
        pad_cw2     = bus.flush && !accept && (state == HALF);
    end

    // Codeword pair registers; an all-zero word is the valid codeword of nibble 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw1_q <= '0;
            cw2_q <= '0;
        end else begin
            if (load_cw1) cw1_q <= enc_word;
            if (load_cw2) cw2_q <= enc_word;
            else if (pad_cw2) cw2_q <= '0;
        end
    end

    // Count of pairs handed downstream, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (handoff) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.code_word1 = cw1_q;
    assign bus.code_word2 = cw2_q;
    assign bus.pair_cnt   = cnt_q;
endmodule

// File: tb/tb_hamming_pair_encoder.sv
// tb/tb_hamming_pair_encoder.sv - scoreboard bench for hamming_pair_encoder
module tb_hamming_pair_encoder;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_pair_encoder_if #(.CNT_W(CNT_W)) ifc ();
    hamming_pair_encoder_if #(.CNT_W(CNT_W)) ifc0 ();

    hamming_pair_encoder #(.ERR_INJ(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );
    hamming_pair_encoder #(.ERR_INJ(1'b0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifc0)
    );

    assign ifc0.in_valid  = ifc.in_valid;
    assign ifc0.in_data   = ifc.in_data;
    assign ifc0.err_pos   = ifc.err_pos;
    assign ifc0.flush     = ifc.flush;
    assign ifc0.out_ready = ifc.out_ready;

    typedef struct packed {
        logic [6:0] w1;
        logic [6:0] w2;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [2:0] e1;
        logic [2:0] e2;
    } pair_t;

    pair_t      exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic       half_v = 1'b0;
    logic [6:0] half_w;
    logic [3:0] half_d;
    logic [2:0] half_e;
    logic       last_acc;

    function automatic logic [6:0] ref_enc(input logic [3:0] d, input logic [2:0] e);
        logic [7:0] p;
        int dpos [4];
        dpos = '{3, 5, 6, 7};
        p = '0;
        for (int i = 0; i < 4; i++) p[dpos[i]] = d[i];
        for (int k = 1; k < 8; k = k * 2)
            for (int j = 1; j < 8; j++)
                if (((j & k) != 0) && (j != k)) p[k] = p[k] ^ p[j];
        if (e != 3'd0) p[e] = ~p[e];
        return p[7:1];
    endfunction

    function automatic logic [2:0] ref_syn(input logic [6:0] w);
        int s = 0;
        for (int j = 1; j < 8; j++) if (w[j-1]) s = s ^ j;
        return 3'(s);
    endfunction

    function automatic logic [3:0] ref_dec(input logic [6:0] w);
        logic [7:0] p;
        logic [2:0] s;
        p = {w, 1'b0};
        s = ref_syn(w);
        if (s != 3'd0) p[s] = ~p[s];
        return {p[7], p[6], p[5], p[3]};
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1
    task automatic cyc(input logic v, input logic [3:0] d, input logic [2:0] e,
                       input logic f, input logic r);
        pair_t p;
        ifc.in_valid  = v;
        ifc.in_data   = d;
        ifc.err_pos   = e;
        ifc.flush     = f;
        ifc.out_ready = r;
        #3;
        last_acc = v && ifc.in_ready;
        if (last_acc) begin
            if (!half_v) begin
                half_v = 1'b1;
                half_w = ref_enc(d, e);
                half_d = d;
                half_e = e;
            end else begin
                p = '{half_w, ref_enc(d, e), half_d, d, half_e, e};
                exp_q.push_back(p);
                half_v = 1'b0;
            end
        end else if (f && half_v) begin
            p = '{half_w, 7'h00, half_d, 4'h0, half_e, 3'd0};
            exp_q.push_back(p);
            half_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.err_pos = '0;
        ifc.flush = 1'b0; ifc.out_ready = 1'b0;
        exp_q.delete();
        half_v = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int         mon_cnt = 0;
    logic       held = 1'b0;
    logic [6:0] held_w1, held_w2;

    // Monitor: pops the scoreboard on every handshake and guards held pairs
    always @(negedge clk) begin
        pair_t p;
        if (!rst_n) begin
            mon_cnt = 0;
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_out_valid", ifc.out_valid, 1);
                chk("hold_w1", ifc.code_word1, held_w1);
                chk("hold_w2", ifc.code_word2, held_w2);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                chk("pair_cnt", ifc.pair_cnt, mon_cnt % 256);
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pair: got %0h/%0h expected none",
                             ifc.code_word1, ifc.code_word2);
                end else begin
                    p = exp_q.pop_front();
                    chk("sb_w1", ifc.code_word1, p.w1);
                    chk("sb_w2", ifc.code_word2, p.w2);
                    chk("syn_w1", ref_syn(ifc.code_word1), p.e1);
                    chk("dec_w1", ref_dec(ifc.code_word1), p.d1);
                    chk("syn_w2", ref_syn(ifc.code_word2), p.e2);
                    chk("dec_w2", ref_dec(ifc.code_word2), p.d2);
                end
                mon_cnt++;
            end
            held    = ifc.out_valid && !ifc.out_ready;
            held_w1 = ifc.code_word1;
            held_w2 = ifc.code_word2;
        end
    end

    int bubbles;

    initial begin
        do_reset();
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_w1", ifc.code_word1, 0);
        chk("rst_w2", ifc.code_word2, 0);
        chk("rst_pair_cnt", ifc.pair_cnt, 0);

        // Basic pair
        cyc(1, 4'hB, 0, 0, 1);
        chk("b_out_valid_half", ifc.out_valid, 0);
        cyc(1, 4'h1, 0, 0, 1);
        chk("b_out_valid", ifc.out_valid, 1);
        chk("b_w1", ifc.code_word1, 7'h55);
        chk("b_w2", ifc.code_word2, 7'h07);
        cyc(0, 0, 0, 0, 1);
        chk("b_pair_cnt", ifc.pair_cnt, 1);
        chk("b_out_valid_after", ifc.out_valid, 0);

        // Error injection, and the non-injecting variant
        cyc(1, 4'hF, 3'd3, 0, 1);
        cyc(1, 4'h0, 3'd7, 0, 1);
        chk("inj_w1", ifc.code_word1, 7'h7B);
        chk("inj_w2", ifc.code_word2, 7'h40);
        chk("noinj_valid", ifc0.out_valid, 1);
        chk("noinj_w1", ifc0.code_word1, 7'h7F);
        chk("noinj_w2", ifc0.code_word2, 7'h00);
        cyc(0, 0, 0, 0, 1);

        // Backpressure then same-edge handoff and accept
        cyc(1, 4'hA, 0, 0, 0);
        cyc(1, 4'h5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", ifc.in_ready, 0);
            chk("bp_out_valid", ifc.out_valid, 1);
            cyc(1, 4'hC, 0, 0, 0);
            chk("bp_no_accept", last_acc, 0);
        end
        cyc(1, 4'hC, 0, 0, 1);
        chk("bp_accept", last_acc, 1);
        chk("bp_half_valid", ifc.out_valid, 0);
        chk("bp_half_w1", ifc.code_word1, ref_enc(4'hC, 0));
        cyc(0, 0, 0, 1, 1);
        chk("bp_flush_w2", ifc.code_word2, 0);
        cyc(0, 0, 0, 0, 1);

        // Flush closes a half pair; flush when empty does nothing
        cyc(1, 4'hF, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        chk("fl_valid", ifc.out_valid, 1);
        chk("fl_w1", ifc.code_word1, 7'h7F);
        chk("fl_w2", ifc.code_word2, 7'h00);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        chk("fl_empty_valid", ifc.out_valid, 0);
        cyc(0, 0, 0, 0, 1);
        chk("fl_empty_valid2", ifc.out_valid, 0);

        // Asynchronous reset while a half pair is held
        cyc(1, 4'h6, 0, 0, 1);
        chk("ar_w1_loaded", ifc.code_word1, ref_enc(4'h6, 0));
        #1;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        chk("ar_w1", ifc.code_word1, 0);
        chk("ar_out_valid", ifc.out_valid, 0);
        chk("ar_pair_cnt", ifc.pair_cnt, 0);
        half_v = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ar_in_ready", ifc.in_ready, 1);
        cyc(1, 4'h9, 0, 0, 1);
        cyc(1, 4'h3, 0, 0, 1);
        chk("ar_new_w1", ifc.code_word1, ref_enc(4'h9, 0));
        chk("ar_new_w2", ifc.code_word2, ref_enc(4'h3, 0));
        cyc(0, 0, 0, 0, 1);

        // Back-to-back stream of 2^CNT_W+1 pairs
        do_reset();
        bubbles = 0;
        for (int i = 0; i < 2 * ((1 << CNT_W) + 1); i++) begin
            cyc(1, 4'($urandom), 3'($urandom), 0, 1);
            if (!last_acc) bubbles++;
        end
        cyc(0, 0, 0, 0, 1);
        chk("st_bubbles", bubbles, 0);
        chk("st_pair_cnt_wrap", ifc.pair_cnt, 1);

        // Random traffic with backpressure and flushes
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_out_valid", ifc.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
